// File: rtl/i2s_tx_if.sv
// Sample-pair input channel of the I2S serializer.
// A pair transfers on a clki edge where in_valid & in_ready; the source holds data stable while in_valid is high.
interface i2s_tx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] left_i;
    logic [WIDTH-1:0] right_i;
    logic             in_valid;
    logic             in_ready;

    modport master (output left_i, output right_i, output in_valid, input in_ready);
    modport slave  (input left_i, input right_i, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_tx.sv
// Stereo Philips-I2S serializer: one buffered {L,R} pair per frame, shifted MSB-first
// on falling edges of an oversampled bit clock, with underrun flagging.
module i2s_tx #(
    parameter int WIDTH = 16
) (
    input  logic      clki,
    input  logic      rst_n,
    input  logic      sclk_i,
    input  logic      en,
    i2s_tx_if.slave   s_in,
    output logic      bclk_o,
    output logic      ws_o,
    output logic      sd_o,
    output logic      underrun
);
    localparam int SLOTS = 2 * WIDTH;
    localparam int CW    = $clog2(SLOTS);
    typedef logic [CW-1:0] cnt_t;

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    cnt_t             r_cnt;
    logic [SLOTS-1:0] r_sh;
    logic [WIDTH-1:0] r_left;
    logic [WIDTH-1:0] r_right;
    logic             r_full;

    logic             w_fall;
    cnt_t             w_cnt_nxt;
    logic             w_write;
    logic             w_load;

    always_comb begin
        w_fall    = r_s3 & ~r_s2;
        w_cnt_nxt = r_cnt + 1'b1;
        w_write   = s_in.in_valid & ~r_full;
        w_load    = w_fall & en & (w_cnt_nxt == cnt_t'(1));
    end

    assign s_in.in_ready = ~r_full;

    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            bclk_o   <= 1'b0;
            r_cnt    <= '1;
            ws_o     <= 1'b1;
            sd_o     <= 1'b0;
            r_sh     <= '0;
            r_left   <= '0;
            r_right  <= '0;
            r_full   <= 1'b0;
            underrun <= 1'b0;
        end else begin
            r_s1     <= sclk_i;
            r_s2     <= r_s1;
            r_s3     <= r_s2;
            bclk_o   <= r_s2;
            underrun <= 1'b0;

            if (w_write) begin
                r_left  <= s_in.left_i;
                r_right <= s_in.right_i;
            end

            // A load with an empty buffer does not block a write landing on the same edge.
            if (w_load && r_full) begin
                r_full <= 1'b0;
            end else if (w_write) begin
                r_full <= 1'b1;
            end

            if (!en) begin
                r_cnt <= '1;
                ws_o  <= 1'b1;
                sd_o  <= 1'b0;
                r_sh  <= '0;
            end else if (w_fall) begin
                r_cnt <= w_cnt_nxt;
                // WIDTH is half the frame and a power of two, so the counter MSB marks the right half.
                ws_o  <= w_cnt_nxt[CW-1];
                if (w_load) begin
                    if (r_full) begin
                        sd_o <= r_left[WIDTH-1];
                        r_sh <= {r_left[WIDTH-2:0], r_right, 1'b0};
                    end else begin
                        sd_o     <= 1'b0;
                        r_sh     <= '0;
                        underrun <= 1'b1;
                    end
                end else begin
                    sd_o <= r_sh[SLOTS-1];
                    r_sh <= {r_sh[SLOTS-2:0], 1'b0};
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: frames are rebuilt from the serial line at bclk_o rising edges and
// compared against the queue of accepted sample pairs.
module tb_i2s_tx;
    localparam int WIDTH = 16;
    localparam int HALF  = 6;
    localparam int FRAME_CYC = 2 * WIDTH * 2 * HALF;

    logic clki   = 1'b0;
    logic rst_n  = 1'b0;
    logic sclk_i = 1'b0;
    logic en     = 1'b0;
    logic bclk_o;
    logic ws_o;
    logic sd_o;
    logic underrun;

    i2s_tx_if #(.WIDTH(WIDTH)) bus();

    i2s_tx #(.WIDTH(WIDTH)) dut (
        .clki     (clki),
        .rst_n    (rst_n),
        .sclk_i   (sclk_i),
        .en       (en),
        .s_in     (bus),
        .bclk_o   (bclk_o),
        .ws_o     (ws_o),
        .sd_o     (sd_o),
        .underrun (underrun)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    logic [2*WIDTH-1:0] exp_q[$];

    int acc_cnt = 0;
    int last_acc_rise = 0;
    int fall_cnt = 0;
    int div_cnt = 0;

    int   rise_cnt = 0;
    int   frame_cnt = 0;
    int   ur_total = 0;
    int   slot_idx = 0;
    bit   frame_valid = 0;
    bit   cur_ur = 0;
    int   en_hi = 0;
    int   en_lo = 0;
    logic p_bclk = 1'b0;
    logic p_ws = 1'b1;
    logic p_sd = 1'b0;
    logic p_ur = 1'b0;
    logic last_ws = 1'b1;
    logic [2*WIDTH-1:0] bits = '0;
    logic [2*WIDTH-1:0] m_word = '0;
    logic [2*WIDTH-1:0] m_exp = '0;
    logic [2*WIDTH-1:0] last_word = '0;
    logic [2*WIDTH-1:0] last_nz_word = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // clock / bit clock / watchdog
    initial forever #5 clki = ~clki;

    initial forever begin
        @(negedge clki);
        if (div_cnt == HALF - 1) begin
            div_cnt = 0;
            if (sclk_i) fall_cnt++;
            sclk_i = ~sclk_i;
        end else begin
            div_cnt++;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1, "watchdog");
    end

    // accepted pairs become the expected frame contents, in order
    initial forever begin
        @(posedge clki);
        if (rst_n && bus.in_valid && bus.in_ready) begin
            exp_q.push_back({bus.left_i, bus.right_i});
            acc_cnt++;
            last_acc_rise = rise_cnt;
        end
    end

    // serial-line monitor and scoreboard
    initial forever begin
        @(negedge clki);
        if (!rst_n) begin
            p_bclk = bclk_o; p_ws = ws_o; p_sd = sd_o; p_ur = 1'b0;
            last_ws = 1'b1; frame_valid = 0; cur_ur = 0; en_hi = 0; en_lo = 0;
        end else begin
            if (en) begin en_hi++; en_lo = 0; end
            else begin en_lo++; en_hi = 0; end
            if (underrun) begin
                ur_total++;
                cur_ur = 1;
                check("ur_width", {31'd0, p_ur}, 32'd0);
            end
            if (!en) begin
                if (frame_valid && slot_idx >= 1 && !cur_ur && exp_q.size() > 0)
                    void'(exp_q.pop_front());
                frame_valid = 0;
                cur_ur = 0;
            end
            if (en_hi >= 2 && (ws_o !== p_ws || sd_o !== p_sd))
                check("edge_align", {30'd0, p_bclk, bclk_o}, 32'd2);
            if (!p_bclk && bclk_o) begin
                rise_cnt++;
                if (!en) begin
                    if (en_lo >= 2) begin
                        check("idle_ws", {31'd0, ws_o}, 32'd1);
                        check("idle_sd", {31'd0, sd_o}, 32'd0);
                    end
                end else if (last_ws && !ws_o) begin
                    if (frame_valid) begin
                        m_word = {bits[2*WIDTH-2:0], sd_o};
                        check("frame_len", slot_idx, 31);
                        if (cur_ur) begin
                            m_exp = '0;
                        end else if (exp_q.size() == 0) begin
                            check("exp_empty", 32'd0, 32'd1);
                            m_exp = '0;
                        end else begin
                            m_exp = exp_q.pop_front();
                            last_nz_word = m_word;
                        end
                        check("frame_data", m_word, m_exp);
                        last_word = m_word;
                    end
                    frame_cnt++;
                    frame_valid = 1;
                    slot_idx = 0;
                    cur_ur = 0;
                    bits = '0;
                end else if (frame_valid) begin
                    slot_idx++;
                    bits = {bits[2*WIDTH-2:0], sd_o};
                    check("ws_slot", {31'd0, ws_o}, (slot_idx >= WIDTH) ? 32'd1 : 32'd0);
                end
                last_ws = ws_o;
            end
            p_bclk = bclk_o; p_ws = ws_o; p_sd = sd_o; p_ur = underrun;
        end
    end

    // driver tasks
    task automatic send_pair(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        int a;
        bit got;
        a = acc_cnt;
        got = 0;
        bus.left_i = l;
        bus.right_i = r;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            @(negedge clki); #1;
            if (acc_cnt != a) begin got = 1; break; end
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int f;
        f = frame_cnt;
        for (int i = 0; i < (n + 1) * FRAME_CYC; i++) begin
            @(negedge clki); #1;
            if (frame_cnt >= f + n) return;
        end
        check("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_slot(input int n);
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            @(negedge clki); #1;
            if (frame_valid && slot_idx == n) return;
        end
        check("slot_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_bclk_fall(input string tag);
        logic p;
        p = bclk_o;
        for (int i = 0; i < 8 * HALF; i++) begin
            @(negedge clki);
            if (p && !bclk_o) begin
                check(tag, {31'd0, ws_o}, 32'd0);
                #1;
                return;
            end
            p = bclk_o;
        end
        check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 4 * FRAME_CYC; i++) begin
            @(negedge clki); #1;
            if (exp_q.size() == 0 && bus.in_ready) return;
        end
        check("drain_timeout", 32'd0, 32'd1);
    endtask

    // directed sequence
    initial begin
        int a;
        int u;
        int f;
        int prev_rise;
        bit got;
        logic [2*WIDTH-1:0] d;

        bus.in_valid = 1'b0;
        bus.left_i = '0;
        bus.right_i = '0;
        repeat (5) @(negedge clki);
        #1;
        check("rst_ws", {31'd0, ws_o}, 32'd1);
        check("rst_sd", {31'd0, sd_o}, 32'd0);
        check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_ur", {31'd0, underrun}, 32'd0);
        check("rst_bclk", {31'd0, bclk_o}, 32'd0);
        rst_n = 1'b1;
        en = 1'b1;
        wait_bclk_fall("rst_first_ws");

        // single known frame
        send_pair(16'hA5F0, 16'h0F3C);
        wait_drain();
        check("known_frame", last_nz_word, 32'hA5F00F3C);

        // backpressure: continuous valid with incrementing data
        bus.in_valid = 1'b1;
        prev_rise = 0;
        for (int k = 0; k < 6; k++) begin
            bus.left_i = 16'h1000 + 16'(k);
            bus.right_i = 16'h2000 + 16'(k);
            a = acc_cnt;
            got = 0;
            for (int i = 0; i < 3 * FRAME_CYC; i++) begin
                @(negedge clki); #1;
                if (acc_cnt != a) begin got = 1; break; end
            end
            if (!got) check("bp_timeout", 32'd0, 32'd1);
            check("bp_ready_low", {31'd0, bus.in_ready}, 32'd0);
            if (k >= 2) check("bp_spacing", last_acc_rise - prev_rise, 32'd32);
            prev_rise = last_acc_rise;
        end
        bus.in_valid = 1'b0;
        wait_drain();
        check("bp_last", last_nz_word, {16'h1005, 16'h2005});

        // underrun: two empty frames
        wait_frames(1);
        u = ur_total;
        wait_frames(2);
        check("ur_count", ur_total - u, 32'd2);
        check("ur_zero_frame", last_word, 32'd0);

        // write landing exactly on an empty-buffer load edge
        f = fall_cnt;
        for (int i = 0; i < 4 * HALF; i++) begin
            @(negedge clki); #1;
            if (fall_cnt != f) break;
        end
        @(negedge clki);
        @(negedge clki); #1;
        d = {16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535))};
        bus.left_i = d[31:16];
        bus.right_i = d[15:0];
        bus.in_valid = 1'b1;
        a = acc_cnt;
        u = ur_total;
        @(negedge clki); #1;
        bus.in_valid = 1'b0;
        check("lc_accept", acc_cnt - a, 32'd1);
        check("lc_underrun", ur_total - u, 32'd1);
        wait_frames(2);
        check("lc_data", last_word, d);

        // enable low for three frames with a pair buffered
        wait_slot(8);
        d = {16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535))};
        send_pair(d[31:16], d[15:0]);
        en = 1'b0;
        repeat (3 * FRAME_CYC) @(negedge clki);
        #1;
        check("en_retained", {31'd0, bus.in_ready}, 32'd0);
        check("en_idle_ws", {31'd0, ws_o}, 32'd1);
        check("en_idle_sd", {31'd0, sd_o}, 32'd0);
        en = 1'b1;
        wait_bclk_fall("en_restart_ws");
        wait_frames(2);
        check("en_data", last_word, d);

        // randomized pairs with random gaps
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 400)) @(negedge clki);
            #1;
            send_pair(16'($urandom), 16'($urandom));
        end
        wait_drain();
        wait_frames(1);

        // asynchronous reset mid-frame with the buffer full
        wait_slot(10);
        send_pair(16'h1234, 16'h5678);
        @(negedge clki); #1;
        check("pre_rst_ready", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ws", {31'd0, ws_o}, 32'd1);
        check("mid_rst_sd", {31'd0, sd_o}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_rst_ur", {31'd0, underrun}, 32'd0);
        repeat (3) @(negedge clki);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        wait_bclk_fall("rst2_first_ws");
        send_pair(16'hC3C3, 16'h3C3C);
        wait_drain();
        check("post_rst_frame", last_nz_word, 32'hC3C33C3C);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
